nco_iq: RTL and testbench

Parametrised numerically-controlled oscillator for the DPSK modem: phase accumulator with base frequency word plus signed per-sample delta step, quarter-wave sine LUT, and simultaneous sin/cos outputs. It adds three things a single-output VCO lacks: a 180° phase-flip input for DPSK symbol modulation, a registered valid strobe, and full width/depth parametrisation. The carrier loop drives `dlt_step`, and the mixer consumes `sin_out`/`cos_out` qualified by `out_valid`.

---
 rtl/nco_iq.sv | 164 ++++++++++++++++
 tb/tb_nco_iq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_iq.sv
// I/Q numerically-controlled oscillator: phase accumulator with signed delta trim,
// 180-degree flip for DPSK, quarter-wave sine ROM and a three-stage sin/cos pipeline.
module nco_iq #(
    parameter int PHASE_W = 16,
    parameter int DLT_W   = 11,
    parameter int OUT_W   = 8,
    parameter int LUT_AW  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [PHASE_W-1:0]        fcw_base,
    input  logic [DLT_W-1:0]          dlt_step,
    input  logic                      phase_flip,
    output logic signed [OUT_W-1:0]   sin_out,
    output logic signed [OUT_W-1:0]   cos_out,
    output logic                      out_valid
);

    localparam int MAG_W = OUT_W - 1;
    localparam int DEPTH = 2 ** LUT_AW;
    localparam int AMP   = (2 ** (OUT_W - 1)) - 1;
    localparam int PH_W  = LUT_AW + 2;

    // Midpoint-sampled quarter sine in Q30 fixed point (Taylor series), rounded to MAG_W bits.
    function automatic logic [MAG_W-1:0] table_entry(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        x    = (64'sd3373259426 * longint'(2 * k + 1)) >>> (LUT_AW + 2);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 9; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        scaled = (longint'(AMP) * sum + (64'sd1 <<< 29)) >>> 30;
        return scaled[MAG_W-1:0];
    endfunction

    logic [MAG_W-1:0] rom_s [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [MAG_W-1:0] ROM_VAL = table_entry(k);
        assign rom_s[k] = ROM_VAL;
    end

    logic [PHASE_W-1:0] acc_r;
    logic               flip_r;
    logic [PH_W-1:0]    ph_r;
    logic               v1_r;

    logic [PHASE_W-1:0] inc_s;
    logic               flip_n_s;

    assign inc_s    = fcw_base + PHASE_W'($signed(dlt_step));
    assign flip_n_s = flip_r ^ phase_flip;

    // Stage 1: advance the accumulator and latch the (flipped) table-resolution phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= {PHASE_W{1'b0}};
            flip_r <= 1'b0;
            ph_r   <= {PH_W{1'b0}};
            v1_r   <= 1'b0;
        end else begin
            v1_r <= rd_en;
            if (rd_en) begin
                // Adding the flip at the MSB only toggles the top bit of the sample phase.
                ph_r   <= {acc_r[PHASE_W-1] ^ flip_n_s, acc_r[PHASE_W-2 -: PH_W-1]};
                acc_r  <= acc_r + inc_s;
                flip_r <= flip_n_s;
            end else begin
                ph_r   <= ph_r;
                acc_r  <= acc_r;
                flip_r <= flip_r;
            end
        end
    end

    logic [1:0]        q_s;
    logic [1:0]        qc_s;
    logic [LUT_AW-1:0] idx_s;
    logic [LUT_AW-1:0] sin_addr_s;
    logic [LUT_AW-1:0] cos_addr_s;

    assign q_s   = ph_r[PH_W-1 -: 2];
    assign qc_s  = q_s + 2'd1;
    assign idx_s = ph_r[LUT_AW-1:0];

    // Odd quadrants walk the quarter table backwards.
    always_comb begin
        sin_addr_s = idx_s;
        cos_addr_s = idx_s;
        if (q_s[0]) begin
            sin_addr_s = ~idx_s;
        end else begin
            sin_addr_s = idx_s;
        end
        if (qc_s[0]) begin
            cos_addr_s = ~idx_s;
        end else begin
            cos_addr_s = idx_s;
        end
    end

    logic [MAG_W-1:0] sin_mag_r;
    logic [MAG_W-1:0] cos_mag_r;
    logic             sin_neg_r;
    logic             cos_neg_r;
    logic             v2_r;

    // Stage 2: ROM read of magnitudes plus sign from the upper half-circle bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_mag_r <= {MAG_W{1'b0}};
            cos_mag_r <= {MAG_W{1'b0}};
            sin_neg_r <= 1'b0;
            cos_neg_r <= 1'b0;
            v2_r      <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                sin_mag_r <= rom_s[sin_addr_s];
                cos_mag_r <= rom_s[cos_addr_s];
                sin_neg_r <= q_s[1];
                cos_neg_r <= qc_s[1];
            end else begin
                sin_mag_r <= sin_mag_r;
                cos_mag_r <= cos_mag_r;
                sin_neg_r <= sin_neg_r;
                cos_neg_r <= cos_neg_r;
            end
        end
    end

    logic [OUT_W-1:0] sin_ext_s;
    logic [OUT_W-1:0] cos_ext_s;

    assign sin_ext_s = {1'b0, sin_mag_r};
    assign cos_ext_s = {1'b0, cos_mag_r};

    // Stage 3: apply sign; magnitudes never exceed AMP so negation cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_out   <= {OUT_W{1'b0}};
            cos_out   <= {OUT_W{1'b0}};
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2_r;
            if (v2_r) begin
                sin_out <= sin_neg_r ? -sin_ext_s : sin_ext_s;
                cos_out <= cos_neg_r ? -cos_ext_s : cos_ext_s;
            end else begin
                sin_out <= sin_out;
                cos_out <= cos_out;
            end
        end
    end

endmodule

// File: tb/tb_nco_iq.sv
// Self-checking bench for nco_iq: scenario tables, hand-written corner sequences and a
// randomized run against a trigonometric reference model.
module tb_nco_iq;

    localparam int  PHASE_W = 16;
    localparam int  DLT_W   = 11;
    localparam int  OUT_W   = 8;
    localparam int  LUT_AW  = 6;
    localparam int  PMOD    = 1 << PHASE_W;
    localparam real AMP     = 127.0;
    localparam real PI      = 3.14159265358979323846;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     rd_en;
    logic [PHASE_W-1:0]       fcw_base;
    logic [DLT_W-1:0]         dlt_step;
    logic                     phase_flip;
    logic signed [OUT_W-1:0]  sin_out;
    logic signed [OUT_W-1:0]  cos_out;
    logic                     out_valid;

    always #5 clk = ~clk;

    nco_iq #(.PHASE_W(PHASE_W), .DLT_W(DLT_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .fcw_base  (fcw_base),
        .dlt_step  (dlt_step),
        .phase_flip(phase_flip),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .out_valid (out_valid)
    );

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int m_acc;
    bit m_flip;
    bit pv [3];
    int ps [3];
    int pc [3];
    int last_s;
    int last_c;
    int got_s [$];
    int got_c [$];
    int cont_s [$];
    int cont_c [$];
    int first_valid;
    int step_n;

    typedef struct {
        string              name;
        logic [PHASE_W-1:0] fcw;
        logic [DLT_W-1:0]   dlt;
        int                 s0;
        int                 c0;
        int                 s1;
        int                 c1;
    } scen_t;

    typedef struct {
        int idx;
        int s;
        int c;
    } point_t;

    scen_t  scens  [4];
    point_t points [4];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Value of a full-circle sine/cosine sampled at the midpoint of the table cell.
    function automatic int ref_val(input int phase, input bit is_cos);
        int  m;
        real th;
        real v;
        m  = phase >> (PHASE_W - 2 - LUT_AW);
        th = 2.0 * PI * (real'(m) + 0.5) / real'(1 << (LUT_AW + 2));
        v  = AMP * (is_cos ? $cos(th) : $sin(th));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic step();
        int phase;
        @(posedge clk);
        step_n++;
        if (rst) begin
            m_acc  = 0;
            m_flip = 1'b0;
            for (int i = 0; i < 3; i++) begin
                pv[i] = 1'b0;
                ps[i] = 0;
                pc[i] = 0;
            end
            last_s = 0;
            last_c = 0;
        end else begin
            pv[2] = pv[1]; ps[2] = ps[1]; pc[2] = pc[1];
            pv[1] = pv[0]; ps[1] = ps[0]; pc[1] = pc[0];
            pv[0] = rd_en;
            if (rd_en) begin
                m_flip = m_flip ^ phase_flip;
                phase  = (m_acc + (m_flip ? PMOD / 2 : 0)) % PMOD;
                ps[0]  = ref_val(phase, 1'b0);
                pc[0]  = ref_val(phase, 1'b1);
                m_acc  = (m_acc + int'(fcw_base) + int'($signed(dlt_step))) & (PMOD - 1);
            end
            if (pv[2]) begin
                last_s = ps[2];
                last_c = pc[2];
            end
        end
        #1;
        chk("out_valid", int'(out_valid), int'(pv[2]));
        chk("sin_out", int'(sin_out), last_s);
        chk("cos_out", int'(cos_out), last_c);
        if (out_valid) begin
            got_s.push_back(int'(sin_out));
            got_c.push_back(int'(cos_out));
            if (first_valid < 0) first_valid = step_n;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        rd_en      = 1'b0;
        phase_flip = 1'b0;
        step();
        chk("reset_sin", int'(sin_out), 0);
        chk("reset_cos", int'(cos_out), 0);
        chk("reset_valid", int'(out_valid), 0);
        rst = 1'b0;
    endtask

    task automatic run_tone(input logic [PHASE_W-1:0] f, input logic [DLT_W-1:0] d,
                            input int n, input bit gated, input int flip_at);
        int sent;
        fcw_base    = f;
        dlt_step    = d;
        sent        = 0;
        step_n      = 0;
        first_valid = -1;
        got_s.delete();
        got_c.delete();
        while (sent < n) begin
            rd_en = gated ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_en) phase_flip = (sent == flip_at);
            else       phase_flip = 1'($urandom_range(0, 1));
            step();
            if (rd_en) sent++;
        end
        rd_en      = 1'b0;
        phase_flip = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rst        = 1'b0;
        rd_en      = 1'b0;
        phase_flip = 1'b0;
        fcw_base   = '0;
        dlt_step   = '0;
        m_acc      = 0;
        m_flip     = 1'b0;
        last_s     = 0;
        last_c     = 0;
        step_n     = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; ps[i] = 0; pc[i] = 0;
        end

        scens[0] = '{"delta_cancel", 16'h0400, 11'h400, 2, 127, 2, 127};
        scens[1] = '{"wrap_zero",    16'hFFFF, 11'h001, 2, 127, 2, 127};
        scens[2] = '{"half_rate",    16'h8000, 11'h000, 2, 127, -2, -127};
        scens[3] = '{"dc_zero",      16'h0000, 11'h000, 2, 127, 2, 127};
        points[0] = '{0, 2, 127};
        points[1] = '{16, 127, -2};
        points[2] = '{32, -2, -127};
        points[3] = '{48, -127, 2};

        // basic tone
        do_reset();
        run_tone(16'h0400, 11'h000, 130, 1'b0, -1);
        chk("first_valid_cycle", first_valid, 3);
        chk("tone_count", got_s.size(), 130);
        cont_s = got_s;
        cont_c = got_c;
        for (int i = 0; i < 4; i++) begin
            if (points[i].idx < cont_s.size()) begin
                chk($sformatf("tone_sin_%0d", points[i].idx), cont_s[points[i].idx], points[i].s);
                chk($sformatf("tone_cos_%0d", points[i].idx), cont_c[points[i].idx], points[i].c);
            end
        end
        for (int k = 0; k + 64 < cont_s.size(); k++) begin
            chk("period_sin", cont_s[k + 64], cont_s[k]);
        end

        // gapped strobe, with ignored flip pulses on idle cycles
        do_reset();
        run_tone(16'h0400, 11'h000, 80, 1'b1, -1);
        chk("gapped_count", got_s.size(), 80);
        for (int k = 0; k < 80 && k < got_s.size(); k++) begin
            chk("gapped_sin", got_s[k], cont_s[k]);
            chk("gapped_cos", got_c[k], cont_c[k]);
        end

        // constant / alternating scenarios
        for (int v = 0; v < 4; v++) begin
            do_reset();
            run_tone(scens[v].fcw, scens[v].dlt, 8, 1'b0, -1);
            chk({scens[v].name, "_count"}, got_s.size(), 8);
            for (int k = 0; k < 8 && k < got_s.size(); k++) begin
                chk({scens[v].name, "_sin"}, got_s[k], (k % 2 == 1) ? scens[v].s1 : scens[v].s0);
                chk({scens[v].name, "_cos"}, got_c[k], (k % 2 == 1) ? scens[v].c1 : scens[v].c0);
            end
        end

        // phase flip on sample 5; idle-cycle pulses must not add further flips
        do_reset();
        run_tone(16'h0400, 11'h000, 40, 1'b1, 5);
        chk("flip_count", got_s.size(), 40);
        for (int k = 0; k < 40 && k < got_s.size(); k++) begin
            chk("flip_sin", got_s[k], (k < 5) ? cont_s[k] : -cont_s[k]);
            chk("flip_cos", got_c[k], (k < 5) ? cont_c[k] : -cont_c[k]);
        end

        // reset mid-stream with samples in flight
        do_reset();
        fcw_base   = 16'h0400;
        dlt_step   = 11'h000;
        rd_en      = 1'b1;
        phase_flip = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        chk("midrst_sin", int'(sin_out), 0);
        chk("midrst_cos", int'(cos_out), 0);
        chk("midrst_valid", int'(out_valid), 0);
        rst = 1'b0;
        run_tone(16'h0400, 11'h000, 20, 1'b0, -1);
        chk("midrst_first_valid", first_valid, 3);
        chk("midrst_count", got_s.size(), 20);
        for (int k = 0; k < 20 && k < got_s.size(); k++) begin
            chk("midrst_sin_seq", got_s[k], cont_s[k]);
            chk("midrst_cos_seq", got_c[k], cont_c[k]);
        end

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                fcw_base = 16'($urandom_range(0, PMOD - 1));
                dlt_step = 11'($urandom_range(0, 2047));
            end
            rst        = ($urandom_range(0, 199) == 0);
            rd_en      = ($urandom_range(0, 3) != 0);
            phase_flip = ($urandom_range(0, 7) == 0);
            step();
        end
        rst        = 1'b0;
        rd_en      = 1'b0;
        phase_flip = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
